// File: rtl/smi_mem_test_pkg.sv
// rtl/smi_mem_test_pkg.sv - shared types and constants for the read test sequencer
package smi_mem_test_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } seq_state_t;

    // Sliced down to COUNT_W by the user; all ones means "no failure seen".
    localparam logic [63:0] FIRST_FAIL_NONE = '1;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] len;
        logic [7:0]  opts;
        logic [63:0] data_init;
        logic [63:0] data_incr;
    } burst_params_t;

    function automatic logic xfer(input logic valid, input logic stop);
        return valid & ~stop;
    endfunction

endpackage

// File: rtl/smi_mem_read_test_sequencer_if.sv
// rtl/smi_mem_read_test_sequencer_if.sv - config, checker and result handshakes of the sequencer
interface smi_mem_read_test_sequencer_if #(
    parameter int COUNT_W = 16
);
    logic               cfgValid;
    logic [63:0]        cfgBaseAddr;
    logic [63:0]        cfgAddrStride;
    logic [31:0]        cfgBurstLen;
    logic [7:0]         cfgBurstOpts;
    logic [COUNT_W-1:0] cfgBurstCount;
    logic [63:0]        cfgDataInit;
    logic [63:0]        cfgDataIncr;
    logic [63:0]        cfgDataStep;
    logic               cfgStop;

    logic               testParamsValid;
    logic [63:0]        testParamBurstAddr;
    logic [31:0]        testParamBurstLen;
    logic [7:0]         testParamBurstOpts;
    logic [63:0]        testParamDataInit;
    logic [63:0]        testParamDataIncr;
    logic               testParamsStop;

    logic               testDoneValid;
    logic               testDoneStatusOk;
    logic               testDoneStop;

    logic               resultValid;
    logic               resultPass;
    logic [COUNT_W-1:0] resultFailCount;
    logic [COUNT_W-1:0] resultFirstFail;
    logic               resultTimeout;
    logic               resultStop;

    modport master (
        input  cfgValid, cfgBaseAddr, cfgAddrStride, cfgBurstLen, cfgBurstOpts,
               cfgBurstCount, cfgDataInit, cfgDataIncr, cfgDataStep,
        output cfgStop,
        output testParamsValid, testParamBurstAddr, testParamBurstLen,
               testParamBurstOpts, testParamDataInit, testParamDataIncr,
        input  testParamsStop,
        input  testDoneValid, testDoneStatusOk,
        output testDoneStop,
        output resultValid, resultPass, resultFailCount, resultFirstFail, resultTimeout,
        input  resultStop
    );

    modport slave (
        output cfgValid, cfgBaseAddr, cfgAddrStride, cfgBurstLen, cfgBurstOpts,
               cfgBurstCount, cfgDataInit, cfgDataIncr, cfgDataStep,
        input  cfgStop,
        input  testParamsValid, testParamBurstAddr, testParamBurstLen,
               testParamBurstOpts, testParamDataInit, testParamDataIncr,
        output testParamsStop,
        output testDoneValid, testDoneStatusOk,
        input  testDoneStop,
        input  resultValid, resultPass, resultFailCount, resultFirstFail, resultTimeout,
        output resultStop
    );

endinterface

// File: rtl/smi_mem_test_watchdog.sv
// rtl/smi_mem_test_watchdog.sv - per-burst watchdog: clear/enable counter with expiry compare
module smi_mem_test_watchdog #(
    parameter int TIMEOUT_W = 24,
    parameter int TIMEOUT   = 2**20
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    // Counter reads 0 on the first enabled cycle, so the last allowed cycle is TIMEOUT-1.
    localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT - 1);

    logic [TIMEOUT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_enable && (r_count == LIMIT);

endmodule

// File: rtl/smi_mem_read_test_sequencer.sv
// rtl/smi_mem_read_test_sequencer.sv - issues a series of read bursts to the checker and aggregates status
module smi_mem_read_test_sequencer
    import smi_mem_test_pkg::*;
#(
    parameter int COUNT_W   = 16,
    parameter int TIMEOUT_W = 24,
    parameter int TIMEOUT   = 2**20
) (
    input logic                          clk,
    input logic                          srst,
    smi_mem_read_test_sequencer_if.master bus
);

    localparam logic [COUNT_W-1:0] FF_NONE = FIRST_FAIL_NONE[COUNT_W-1:0];

    seq_state_t         r_state;
    burst_params_t      r_params;
    logic [63:0]        r_stride;
    logic [63:0]        r_step;
    logic [COUNT_W-1:0] r_remaining;
    logic [COUNT_W-1:0] r_issue_idx;
    logic [COUNT_W-1:0] r_wait_idx;
    logic [COUNT_W-1:0] r_fail_count;
    logic [COUNT_W-1:0] r_first_fail;
    logic               r_bad_cfg;
    logic               r_timeout;
    logic               r_cfg_stop;
    logic               r_params_valid;
    logic               r_done_stop;
    logic               r_result_valid;

    logic               w_wd_enable;
    logic               w_wd_clear;
    logic               w_expired;

    assign w_wd_enable = (r_state == WAIT);
    assign w_wd_clear  = (r_state != WAIT);

    smi_mem_test_watchdog #(
        .TIMEOUT_W (TIMEOUT_W),
        .TIMEOUT   (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (srst),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_enable),
        .o_expired (w_expired)
    );

    // Handshake outputs are registered alongside the state so they never follow a stop combinationally.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_state        <= IDLE;
            r_params       <= '0;
            r_stride       <= '0;
            r_step         <= '0;
            r_remaining    <= '0;
            r_issue_idx    <= '0;
            r_wait_idx     <= '0;
            r_fail_count   <= '0;
            r_first_fail   <= FF_NONE;
            r_bad_cfg      <= 1'b0;
            r_timeout      <= 1'b0;
            r_cfg_stop     <= 1'b1;
            r_params_valid <= 1'b0;
            r_done_stop    <= 1'b1;
            r_result_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (xfer(bus.cfgValid, r_cfg_stop)) begin
                        r_params     <= '{addr:      bus.cfgBaseAddr,
                                          len:       bus.cfgBurstLen,
                                          opts:      bus.cfgBurstOpts,
                                          data_init: bus.cfgDataInit,
                                          data_incr: bus.cfgDataIncr};
                        r_stride     <= bus.cfgAddrStride;
                        r_step       <= bus.cfgDataStep;
                        r_remaining  <= bus.cfgBurstCount;
                        r_issue_idx  <= '0;
                        r_fail_count <= '0;
                        r_first_fail <= FF_NONE;
                        r_timeout    <= 1'b0;
                        r_bad_cfg    <= 1'b0;
                        r_cfg_stop   <= 1'b1;
                        if (bus.cfgBurstCount == '0) begin
                            r_result_valid <= 1'b1;
                            r_state        <= REPORT;
                        end else if (bus.cfgBurstLen == '0) begin
                            // A zero-length burst would never complete in the checker.
                            r_bad_cfg      <= 1'b1;
                            r_result_valid <= 1'b1;
                            r_state        <= REPORT;
                        end else begin
                            r_params_valid <= 1'b1;
                            r_state        <= ISSUE;
                        end
                    end else begin
                        r_cfg_stop <= 1'b0;
                    end
                end

                ISSUE: begin
                    if (xfer(r_params_valid, bus.testParamsStop)) begin
                        r_params.addr      <= r_params.addr + r_stride;
                        r_params.data_init <= r_params.data_init + r_step;
                        r_remaining        <= r_remaining - 1'b1;
                        r_wait_idx         <= r_issue_idx;
                        r_issue_idx        <= r_issue_idx + 1'b1;
                        r_params_valid     <= 1'b0;
                        r_done_stop        <= 1'b0;
                        r_state            <= WAIT;
                    end
                end

                WAIT: begin
                    // A status landing on the expiry cycle takes priority over the watchdog.
                    if (xfer(bus.testDoneValid, r_done_stop)) begin
                        if (!bus.testDoneStatusOk) begin
                            if (r_fail_count != '1) begin
                                r_fail_count <= r_fail_count + 1'b1;
                            end
                            if (r_first_fail == FF_NONE) begin
                                r_first_fail <= r_wait_idx;
                            end
                        end
                        r_done_stop <= 1'b1;
                        if (r_remaining == '0) begin
                            r_result_valid <= 1'b1;
                            r_state        <= REPORT;
                        end else begin
                            r_params_valid <= 1'b1;
                            r_state        <= ISSUE;
                        end
                    end else if (w_expired) begin
                        r_timeout      <= 1'b1;
                        r_done_stop    <= 1'b1;
                        r_result_valid <= 1'b1;
                        r_state        <= REPORT;
                    end
                end

                REPORT: begin
                    if (xfer(r_result_valid, bus.resultStop)) begin
                        r_result_valid <= 1'b0;
                        r_cfg_stop     <= 1'b0;
                        r_state        <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cfgStop            = r_cfg_stop;
    assign bus.testParamsValid    = r_params_valid;
    assign bus.testParamBurstAddr = r_params.addr;
    assign bus.testParamBurstLen  = r_params.len;
    assign bus.testParamBurstOpts = r_params.opts;
    assign bus.testParamDataInit  = r_params.data_init;
    assign bus.testParamDataIncr  = r_params.data_incr;
    assign bus.testDoneStop       = r_done_stop;
    assign bus.resultValid        = r_result_valid;
    assign bus.resultPass         = (r_fail_count == '0) & ~r_timeout & ~r_bad_cfg;
    assign bus.resultFailCount    = r_fail_count;
    assign bus.resultFirstFail    = r_first_fail;
    assign bus.resultTimeout      = r_timeout;

endmodule

// File: tb/tb_smi_mem_read_test_sequencer.sv
// tb/tb_smi_mem_read_test_sequencer.sv - directed table-driven bench for the read test sequencer
module tb_smi_mem_read_test_sequencer;

    localparam int BUDGET = 200;

    logic clk;
    logic srst;
    int   n_pass;
    int   n_total;
    int   params_accepts;

    smi_mem_read_test_sequencer_if #(.COUNT_W(16)) bus ();

    smi_mem_read_test_sequencer #(
        .COUNT_W   (16),
        .TIMEOUT_W (24),
        .TIMEOUT   (16)
    ) dut (
        .clk  (clk),
        .srst (srst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial params_accepts = 0;
    always @(posedge clk) begin
        if (bus.testParamsValid && !bus.testParamsStop) params_accepts++;
    end

    typedef struct {
        logic [63:0] base;
        logic [63:0] stride;
        logic [31:0] len;
        logic [15:0] count;
        logic [63:0] init;
        logic [63:0] step;
        logic [7:0]  fail_mask;
        logic        exp_pass;
        logic [15:0] exp_fc;
        logic [15:0] exp_ff;
        logic [63:0] exp_last_addr;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic wait_cfg_ready(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            if (!bus.cfgStop) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) chk("cfg_ready_bound", 0, 1);
    endtask

    task automatic wait_params(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            if (bus.testParamsValid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) chk("params_bound", 0, 1);
    endtask

    task automatic wait_result(output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        for (int c = 0; c < BUDGET; c++) begin
            if (bus.resultValid) begin ok = 1'b1; break; end
            waited++;
            @(negedge clk);
        end
        if (!ok) chk("result_bound", 0, 1);
    endtask

    task automatic send_cfg(input logic [63:0] base, input logic [63:0] stride,
                            input logic [31:0] len, input logic [15:0] count,
                            input logic [63:0] init, input logic [63:0] step);
        bit ok;
        wait_cfg_ready(ok);
        bus.cfgValid      = 1'b1;
        bus.cfgBaseAddr   = base;
        bus.cfgAddrStride = stride;
        bus.cfgBurstLen   = len;
        bus.cfgBurstOpts  = 8'hA5;
        bus.cfgBurstCount = count;
        bus.cfgDataInit   = init;
        bus.cfgDataIncr   = 64'h3;
        bus.cfgDataStep   = step;
        @(posedge clk);
        @(negedge clk);
        bus.cfgValid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit ok;
        int acc0;
        int waited;
        int exp_bursts;
        string t;
        t = $sformatf("v%0d", idx);
        exp_bursts = (v.len == 0) ? 0 : int'(v.count);
        acc0 = params_accepts;
        send_cfg(v.base, v.stride, v.len, v.count, v.init, v.step);
        if (v.count == 0 || v.len == 0) begin
            chk({t, "_lat_result"}, bus.resultValid, 1);
            chk({t, "_no_params"}, bus.testParamsValid, 0);
        end else begin
            chk({t, "_lat_params"}, bus.testParamsValid, 1);
        end
        for (int i = 0; i < exp_bursts; i++) begin
            wait_params(ok);
            if (!ok) break;
            chk($sformatf("%s_addr%0d", t, i), bus.testParamBurstAddr, v.base + 64'(i) * v.stride);
            chk($sformatf("%s_seed%0d", t, i), bus.testParamDataInit, v.init + 64'(i) * v.step);
            if (i == 0)
                chk({t, "_len_opts_incr"},
                    {bus.testParamBurstLen, bus.testParamBurstOpts, bus.testParamDataIncr[23:0]},
                    {v.len, 8'hA5, 24'h3});
            if (i == exp_bursts - 1)
                chk({t, "_last_addr"}, bus.testParamBurstAddr, v.exp_last_addr);
            @(posedge clk);
            @(negedge clk);
            bus.testDoneValid    = 1'b1;
            bus.testDoneStatusOk = ~v.fail_mask[i];
            @(posedge clk);
            @(negedge clk);
            bus.testDoneValid = 1'b0;
        end
        wait_result(ok, waited);
        if (ok) begin
            chk({t, "_result_lat"}, 64'(waited), 0);
            chk({t, "_pass"}, bus.resultPass, v.exp_pass);
            chk({t, "_fail_count"}, bus.resultFailCount, v.exp_fc);
            chk({t, "_first_fail"}, bus.resultFirstFail, v.exp_ff);
            chk({t, "_timeout"}, bus.resultTimeout, 0);
            @(posedge clk);
            @(negedge clk);
        end
        chk({t, "_issue_count"}, 64'(params_accepts - acc0), 64'(exp_bursts));
    endtask

    initial begin : main
        bit ok;
        int waited;
        int acc0;
        int hit;
        n_pass  = 0;
        n_total = 0;

        vecs[0] = '{64'h1000, 64'h200, 32'd64, 16'd3, 64'h11, 64'h100, 8'h00,
                    1'b1, 16'd0, 16'hFFFF, 64'h1400};
        vecs[1] = '{64'h2000, 64'h40, 32'd8, 16'd4, 64'h0, 64'h1, 8'b0000_1010,
                    1'b0, 16'd2, 16'd1, 64'h20C0};
        vecs[2] = '{64'h3000, 64'h10, 32'd8, 16'd0, 64'h0, 64'h1, 8'h00,
                    1'b1, 16'd0, 16'hFFFF, 64'h0};
        vecs[3] = '{64'h4000, 64'h10, 32'd0, 16'd5, 64'h0, 64'h1, 8'h00,
                    1'b0, 16'd0, 16'hFFFF, 64'h0};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FF00, 64'h100, 32'd4, 16'd2,
                    64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 8'h00,
                    1'b1, 16'd0, 16'hFFFF, 64'h0};

        srst = 1'b1;
        bus.cfgValid = 1'b0;
        bus.cfgBaseAddr = '0;
        bus.cfgAddrStride = '0;
        bus.cfgBurstLen = '0;
        bus.cfgBurstOpts = '0;
        bus.cfgBurstCount = '0;
        bus.cfgDataInit = '0;
        bus.cfgDataIncr = '0;
        bus.cfgDataStep = '0;
        bus.testParamsStop = 1'b0;
        bus.testDoneValid = 1'b0;
        bus.testDoneStatusOk = 1'b0;
        bus.resultStop = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_cfg_stop", bus.cfgStop, 1);
        chk("rst_params_valid", bus.testParamsValid, 0);
        chk("rst_done_stop", bus.testDoneStop, 1);
        chk("rst_result_valid", bus.resultValid, 0);
        chk("rst_first_fail", bus.resultFirstFail, 16'hFFFF);
        chk("rst_fail_count", bus.resultFailCount, 0);
        srst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_cfg_stop", bus.cfgStop, 0);
        chk("idle_done_stop", bus.testDoneStop, 1);

        for (int k = 0; k < 5; k++) run_vec(vecs[k], k);

        // Params and result backpressure: values must hold and no duplicate issue.
        acc0 = params_accepts;
        bus.testParamsStop = 1'b1;
        send_cfg(64'h8000, 64'h80, 32'd4, 16'd1, 64'h55, 64'h1);
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("bp_params_held%0d", c),
                {bus.testParamsValid, bus.testParamBurstAddr}, {1'b1, 64'h8000});
            @(negedge clk);
        end
        bus.testParamsStop = 1'b0;
        bus.resultStop = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.testDoneValid = 1'b1;
        bus.testDoneStatusOk = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.testDoneValid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_result_held%0d", c),
                {bus.resultValid, bus.resultPass, bus.resultFailCount}, {1'b1, 1'b1, 16'd0});
            @(negedge clk);
        end
        bus.resultStop = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("bp_result_released", bus.resultValid, 0);
        chk("bp_single_issue", 64'(params_accepts - acc0), 1);

        // Watchdog expiry 16 cycles after WAIT entry.
        send_cfg(64'h9000, 64'h80, 32'd4, 16'd1, 64'h0, 64'h1);
        wait_params(ok);
        @(posedge clk);
        hit = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.resultValid) begin hit = c; break; end
        end
        chk("wd_expiry_cycle", 64'(hit), 16);
        chk("wd_timeout_flag", bus.resultTimeout, 1);
        chk("wd_pass", bus.resultPass, 0);
        @(posedge clk);
        @(negedge clk);

        // Status on the expiry cycle wins over the watchdog.
        send_cfg(64'hA000, 64'h80, 32'd4, 16'd1, 64'h0, 64'h1);
        wait_params(ok);
        @(posedge clk);
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("race_still_waiting", {bus.resultValid, bus.testDoneStop}, 0);
        bus.testDoneValid = 1'b1;
        bus.testDoneStatusOk = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.testDoneValid = 1'b0;
        wait_result(ok, waited);
        chk("race_timeout", bus.resultTimeout, 0);
        chk("race_pass", bus.resultPass, 1);
        @(posedge clk);
        @(negedge clk);

        // Reset asserted mid-WAIT.
        send_cfg(64'hB000, 64'h80, 32'd4, 16'd2, 64'h0, 64'h1);
        wait_params(ok);
        @(posedge clk);
        @(negedge clk);
        chk("mid_wait_done_stop", bus.testDoneStop, 0);
        srst = 1'b1;
        #1;
        chk("srst_valids",
            {bus.cfgStop, bus.testParamsValid, bus.testDoneStop, bus.resultValid}, 4'b1010);
        @(negedge clk);
        chk("srst_cfg_stop_held", bus.cfgStop, 1);
        srst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_srst_idle", {bus.cfgStop, bus.testParamsValid, bus.resultValid}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
